// File: rtl/noc_traffic_sink.sv
// NoC ejection endpoint: consumes flits, returns one credit per flit, checks per-VC
// head/body/tail framing and destination, counts packets and signals run completion.
module noc_traffic_sink #(
  parameter int unsigned DEST_W = 10,
  parameter int unsigned VC_W   = 2,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [CNT_W-1:0]  init_num_pkts,
  input  logic [DEST_W-1:0] my_addr,
  input  logic              flit_valid,
  input  logic              flit_head,
  input  logic              flit_tail,
  input  logic [DEST_W-1:0] flit_dst,
  input  logic [VC_W-1:0]   flit_vc,
  output logic              credit_valid,
  output logic [VC_W-1:0]   credit_vc,
  output logic [CNT_W-1:0]  pkts_received,
  output logic [FCNT_W-1:0] flits_received,
  output logic              err_framing,
  output logic              err_dest,
  output logic              done
);

  localparam int unsigned NumVc = 2 ** VC_W;

  typedef enum logic {StIdle, StBody} vc_state_e;

  vc_state_e         vc_state_q [NumVc];
  vc_state_e         vc_state_d [NumVc];
  vc_state_e         cur_state;
  vc_state_e         nxt_state;
  logic              pkt_done;
  logic              frame_err;

  logic              credit_valid_q;
  logic [VC_W-1:0]   credit_vc_q;
  logic [CNT_W-1:0]  pkts_q, pkts_d;
  logic [CNT_W-1:0]  expected_q, expected_d;
  logic [FCNT_W-1:0] flits_q, flits_d;
  logic              err_framing_q, err_framing_d;
  logic              err_dest_q, err_dest_d;
  logic              armed_q, armed_d;
  logic              done_q, done_d;

  // Framing decode for the VC addressed by the current flit.
  always_comb begin
    cur_state = vc_state_q[flit_vc];
    nxt_state = cur_state;
    pkt_done  = 1'b0;
    frame_err = 1'b0;
    unique case (cur_state)
      StIdle: begin
        if (flit_head) begin
          pkt_done  = flit_tail;
          nxt_state = flit_tail ? StIdle : StBody;
        end else begin
          frame_err = 1'b1;
        end
      end
      StBody: begin
        // A head here abandons the open packet and restarts framing from the new head.
        if (flit_head) begin
          frame_err = 1'b1;
          pkt_done  = flit_tail;
          nxt_state = flit_tail ? StIdle : StBody;
        end else if (flit_tail) begin
          pkt_done  = 1'b1;
          nxt_state = StIdle;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    vc_state_d    = vc_state_q;
    pkts_d        = pkts_q;
    expected_d    = expected_q;
    flits_d       = flits_q;
    err_framing_d = err_framing_q;
    err_dest_d    = err_dest_q;
    armed_d       = armed_q;

    if (init) begin
      for (int i = 0; i < NumVc; i++) vc_state_d[i] = StIdle;
      pkts_d        = '0;
      flits_d       = '0;
      err_framing_d = 1'b0;
      err_dest_d    = 1'b0;
      expected_d    = init_num_pkts;
      armed_d       = 1'b1;
    end else if (flit_valid) begin
      vc_state_d[flit_vc] = nxt_state;
      if (flits_q != '1) flits_d = flits_q + FCNT_W'(1);
      if (pkt_done && pkts_q != '1) pkts_d = pkts_q + CNT_W'(1);
      if (frame_err) err_framing_d = 1'b1;
      if (flit_head && flit_dst != my_addr) err_dest_d = 1'b1;
    end

    done_d = armed_d && (pkts_d >= expected_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumVc; i++) vc_state_q[i] <= StIdle;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      pkts_q         <= '0;
      expected_q     <= '0;
      flits_q        <= '0;
      err_framing_q  <= 1'b0;
      err_dest_q     <= 1'b0;
      armed_q        <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      vc_state_q     <= vc_state_d;
      credit_valid_q <= flit_valid;
      credit_vc_q    <= flit_vc;
      pkts_q         <= pkts_d;
      expected_q     <= expected_d;
      flits_q        <= flits_d;
      err_framing_q  <= err_framing_d;
      err_dest_q     <= err_dest_d;
      armed_q        <= armed_d;
      done_q         <= done_d;
    end
  end

  assign credit_valid   = credit_valid_q;
  assign credit_vc      = credit_vc_q;
  assign pkts_received  = pkts_q;
  assign flits_received = flits_q;
  assign err_framing    = err_framing_q;
  assign err_dest       = err_dest_q;
  assign done           = done_q;

endmodule
